// File: rtl/txn_issuer_if.sv
// Bus request channel of the transaction issuer: request handshake plus the
// address, beat count, ID, direction and last-of-request flag.
interface txn_issuer_if #(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned IdWidth   = 4
) ();
  logic                 ax_valid_o;
  logic                 ax_ready_i;
  logic [AddrWidth-1:0] ax_addr_o;
  logic [7:0]           ax_len_o;
  logic [IdWidth-1:0]   ax_id_o;
  logic                 ax_write_o;
  logic                 ax_last_o;

  modport master (
    output ax_valid_o, ax_addr_o, ax_len_o, ax_id_o, ax_write_o, ax_last_o,
    input  ax_ready_i
  );

  modport slave (
    input  ax_valid_o, ax_addr_o, ax_len_o, ax_id_o, ax_write_o, ax_last_o,
    output ax_ready_i
  );
endinterface

// File: rtl/txn_issuer.sv
// Splits segment metadata into page-bounded bus transactions and tracks their completion.
// Optional transaction counter on perf_txn_cnt_o when RIVA_TXN_ISSUER_PERF_EN is defined.
package txn_issuer_pkg;
  typedef struct packed {
    logic [3:0] reqId;
    logic       isLoad;
    logic [7:0] rmnGrp;
    logic [7:0] rmnSeg;
  } meta_glb_t;

  typedef struct packed {
    logic [63:0] segBaseAddr;
    logic [15:0] txnNum;
    logic [15:0] txnCnt;
    logic [15:0] ltN;
  } meta_seglv_t;
endpackage

module txn_issuer #(
  parameter int unsigned NrLanes        = 4,
  parameter int unsigned DLEN           = 128,
  parameter int unsigned AddrWidth      = 64,
  parameter int unsigned MaxOutstanding = 8,
  parameter int unsigned IdWidth        = 4,
  parameter type         meta_glb_t     = txn_issuer_pkg::meta_glb_t,
  parameter type         meta_seglv_t   = txn_issuer_pkg::meta_seglv_t
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               meta_valid_i,
  output logic               meta_ready_o,
  input  meta_glb_t          meta_glb_i,
  input  meta_seglv_t        meta_seglv_i,
  txn_issuer_if.master       ax,
  input  logic               rsp_done_i,
  output logic               req_done_o,
  output logic [IdWidth-1:0] req_done_id_o,
  output logic [31:0]        perf_txn_cnt_o
);

  localparam int unsigned NbPerBeat = DLEN / 4;
  localparam int unsigned NibW      = AddrWidth + 1;
  localparam int unsigned CntW      = $clog2(MaxOutstanding + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;

  if (NrLanes < 1 || (DLEN % 4) != 0) begin : g_param_check
    $error("txn_issuer: NrLanes must be >= 1 and DLEN a multiple of 4");
  end

  logic [1:0]           state_q, state_d;
  logic [CntW-1:0]      outst_q, outst_d;
  logic                 ax_valid_q, ax_valid_d;
  logic [AddrWidth-1:0] ax_addr_q, ax_addr_d;
  logic [7:0]           ax_len_q, ax_len_d;
  logic [IdWidth-1:0]   ax_id_q, ax_id_d;
  logic                 ax_write_q, ax_write_d;
  logic                 ax_last_q, ax_last_d;
  logic                 req_done_q, req_done_d;
  logic [IdWidth-1:0]   req_done_id_q, req_done_id_d;
  logic [IdWidth-1:0]   done_id_q, done_id_d;

  logic [NibW-1:0]      seg_base_s;
  logic [NibW-1:0]      page_base_s;
  logic [NibW-1:0]      txn_off_s;
  logic [NibW-1:0]      start_s;
  logic [NibW-1:0]      start_mod_s;
  logic [12:0]          page_off_s;
  logic [15:0]          ltn_s;
  logic [15:0]          nbs_s;
  logic                 first_txn_s;
  logic                 last_txn_s;
  logic                 last_req_s;
  logic                 ax_fire_s;
  logic                 meta_ready_s;
  logic                 meta_fire_s;

  // Addresses are in nibbles; later transactions of a segment start on 8 KiB-nibble page boundaries.
  assign seg_base_s  = NibW'(meta_seglv_i.segBaseAddr);
  assign page_off_s  = seg_base_s[12:0];
  assign page_base_s = {seg_base_s[NibW-1:13], 13'd0};
  assign txn_off_s   = NibW'(meta_seglv_i.txnCnt) << 5'd13;
  assign ltn_s       = 16'(meta_seglv_i.ltN);
  assign first_txn_s = (meta_seglv_i.txnCnt == '0);
  assign last_txn_s  = (meta_seglv_i.txnCnt == meta_seglv_i.txnNum);
  assign last_req_s  = (meta_glb_i.rmnGrp == '0) && (meta_glb_i.rmnSeg == '0) && last_txn_s;
  assign start_s     = first_txn_s ? seg_base_s : (page_base_s + txn_off_s);
  assign start_mod_s = start_s % NibW'(NbPerBeat);

  // Transaction size in nibbles, clipped by the page offset and the segment tail.
  always_comb begin
    nbs_s = 16'd8192;
    if (meta_seglv_i.txnNum == '0) begin
      nbs_s = ltn_s - {3'd0, page_off_s};
    end else if (first_txn_s) begin
      nbs_s = 16'd8192 - {3'd0, page_off_s};
    end else if (last_txn_s) begin
      nbs_s = ltn_s;
    end else begin
      nbs_s = 16'd8192;
    end
  end

  assign ax_fire_s    = ax_valid_q && ax.ax_ready_i;
  assign meta_ready_s = !rst_i && (state_q != S_DRAIN) && (!ax_valid_q || ax.ax_ready_i)
                        && ((32'(outst_q) + 32'(ax_valid_q)) < 32'(MaxOutstanding));
  assign meta_fire_s  = meta_valid_i && meta_ready_s;

  // Next-state logic for the output stage, outstanding counter and request FSM.
  always_comb begin
    state_d       = state_q;
    outst_d       = outst_q;
    ax_valid_d    = ax_valid_q;
    ax_addr_d     = ax_addr_q;
    ax_len_d      = ax_len_q;
    ax_id_d       = ax_id_q;
    ax_write_d    = ax_write_q;
    ax_last_d     = ax_last_q;
    req_done_d    = 1'b0;
    req_done_id_d = req_done_id_q;
    done_id_d     = done_id_q;

    if (meta_fire_s) begin
      ax_valid_d = 1'b1;
      ax_addr_d  = start_s[AddrWidth:1];
      ax_len_d   = 8'((32'(start_mod_s) + 32'(nbs_s) + 32'(NbPerBeat) - 32'd1)
                      / 32'(NbPerBeat) - 32'd1);
      ax_id_d    = IdWidth'(meta_glb_i.reqId);
      ax_write_d = !meta_glb_i.isLoad;
      ax_last_d  = last_req_s;
    end else if (ax_fire_s) begin
      ax_valid_d = 1'b0;
    end else begin
      ax_valid_d = ax_valid_q;
    end

    // A response arriving at count 0 is dropped, but one paired with a handshake cancels it.
    case ({ax_fire_s, rsp_done_i})
      2'b10: outst_d = outst_q + CntW'(1);
      2'b01: begin
        if (outst_q != '0) begin
          outst_d = outst_q - CntW'(1);
        end else begin
          outst_d = outst_q;
        end
      end
      default: outst_d = outst_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (meta_fire_s) begin
          state_d = S_ACTIVE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACTIVE: begin
        if (ax_fire_s && ax_last_q) begin
          state_d   = S_DRAIN;
          done_id_d = ax_id_q;
        end else begin
          state_d = S_ACTIVE;
        end
      end
      S_DRAIN: begin
        if (outst_q == '0) begin
          state_d       = S_IDLE;
          req_done_d    = 1'b1;
          req_done_id_d = done_id_q;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      outst_q       <= '0;
      ax_valid_q    <= 1'b0;
      ax_addr_q     <= '0;
      ax_len_q      <= 8'd0;
      ax_id_q       <= '0;
      ax_write_q    <= 1'b0;
      ax_last_q     <= 1'b0;
      req_done_q    <= 1'b0;
      req_done_id_q <= '0;
      done_id_q     <= '0;
    end else begin
      state_q       <= state_d;
      outst_q       <= outst_d;
      ax_valid_q    <= ax_valid_d;
      ax_addr_q     <= ax_addr_d;
      ax_len_q      <= ax_len_d;
      ax_id_q       <= ax_id_d;
      ax_write_q    <= ax_write_d;
      ax_last_q     <= ax_last_d;
      req_done_q    <= req_done_d;
      req_done_id_q <= req_done_id_d;
      done_id_q     <= done_id_d;
    end
  end

  assign meta_ready_o  = meta_ready_s;
  assign ax.ax_valid_o = ax_valid_q;
  assign ax.ax_addr_o  = ax_addr_q;
  assign ax.ax_len_o   = ax_len_q;
  assign ax.ax_id_o    = ax_id_q;
  assign ax.ax_write_o = ax_write_q;
  assign ax.ax_last_o  = ax_last_q;
  assign req_done_o    = req_done_q;
  assign req_done_id_o = req_done_id_q;

`ifdef RIVA_TXN_ISSUER_PERF_EN
  logic [31:0] perf_cnt_q, perf_cnt_d;

  assign perf_cnt_d = ax_fire_s ? (perf_cnt_q + 32'd1) : perf_cnt_q;

  // Free-running count of issued transactions.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_cnt_q <= 32'd0;
    end else begin
      perf_cnt_q <= perf_cnt_d;
    end
  end

  assign perf_txn_cnt_o = perf_cnt_q;
`else
  assign perf_txn_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_txn_issuer.sv
// Randomized and directed bench for txn_issuer against a transaction-level reference model.
module tb_txn_issuer;
  localparam int MAX_OUT = 3;

  typedef txn_issuer_pkg::meta_glb_t   glb_t;
  typedef txn_issuer_pkg::meta_seglv_t seg_t;

  typedef struct packed {
    logic [63:0] addr;
    logic [7:0]  len;
    logic [3:0]  id;
    logic        wr;
    logic        last;
  } ax_t;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        meta_valid_i;
  logic        meta_ready_o;
  glb_t        meta_glb_i;
  seg_t        meta_seglv_i;
  logic        rsp_done_i;
  logic        req_done_o;
  logic [3:0]  req_done_id_o;
  logic [31:0] perf_txn_cnt_o;

  txn_issuer_if #(.AddrWidth(64), .IdWidth(4)) ax_if ();

  txn_issuer #(.MaxOutstanding(MAX_OUT)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .meta_valid_i   (meta_valid_i),
    .meta_ready_o   (meta_ready_o),
    .meta_glb_i     (meta_glb_i),
    .meta_seglv_i   (meta_seglv_i),
    .ax             (ax_if),
    .rsp_done_i     (rsp_done_i),
    .req_done_o     (req_done_o),
    .req_done_id_o  (req_done_id_o),
    .perf_txn_cnt_o (perf_txn_cnt_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  bit   s_mv, s_ar, s_rd, s_rst;
  glb_t s_g;
  seg_t s_s;

  int  m_phase;   // 0 idle, 1 request in progress, 2 waiting for responses
  int  m_cnt;
  bit  m_pend;
  ax_t m_ax;
  bit  m_done;
  int  m_done_id;
  int  m_last_id;
  bit  m_fire;
  int  m_txns;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic ax_t expect_txn(input glb_t g, input seg_t s);
    ax_t r;
    longint unsigned base, off, start, nbs, len;
    base  = s.segBaseAddr;
    off   = base % 8192;
    start = (s.txnCnt == 0) ? base : (base / 8192 + longint'(s.txnCnt)) * 8192;
    if (s.txnNum == 0)            nbs = longint'(s.ltN) - off;
    else if (s.txnCnt == 0)       nbs = 8192 - off;
    else if (s.txnCnt == s.txnNum) nbs = longint'(s.ltN);
    else                          nbs = 8192;
    len    = (start % 32 + nbs + 31) / 32 - 1;
    r.addr = start / 2;
    r.len  = len[7:0];
    r.id   = g.reqId;
    r.wr   = !g.isLoad;
    r.last = (g.rmnGrp == 0) && (g.rmnSeg == 0) && (s.txnCnt == s.txnNum);
    return r;
  endfunction

  task automatic step();
    bit exp_ready, ax_fire, meta_fire;
    @(negedge clk);
    rst_i          = s_rst;
    meta_valid_i   = s_mv;
    meta_glb_i     = s_g;
    meta_seglv_i   = s_s;
    ax_if.ax_ready_i = s_ar;
    rsp_done_i     = s_rd;
    #1;
    exp_ready = !s_rst && (m_phase != 2) && (!m_pend || s_ar) && (m_cnt + int'(m_pend) < MAX_OUT);
    check_eq("meta_ready", 64'(meta_ready_o), 64'(exp_ready));
    check_eq("ax_valid", 64'(ax_if.ax_valid_o), 64'(m_pend));
    if (m_pend) begin
      check_eq("ax_addr", ax_if.ax_addr_o, m_ax.addr);
      check_eq("ax_len", 64'(ax_if.ax_len_o), 64'(m_ax.len));
      check_eq("ax_id", 64'(ax_if.ax_id_o), 64'(m_ax.id));
      check_eq("ax_write", 64'(ax_if.ax_write_o), 64'(m_ax.wr));
      check_eq("ax_last", 64'(ax_if.ax_last_o), 64'(m_ax.last));
    end
    check_eq("req_done", 64'(req_done_o), 64'(m_done));
    if (m_done) check_eq("req_done_id", 64'(req_done_id_o), 64'(m_done_id));
`ifdef RIVA_TXN_ISSUER_PERF_EN
    check_eq("perf_cnt", 64'(perf_txn_cnt_o), 64'(m_txns));
`else
    check_eq("perf_cnt", 64'(perf_txn_cnt_o), 64'd0);
`endif
    if (s_rst) begin
      m_phase = 0; m_cnt = 0; m_pend = 0; m_done = 0; m_done_id = 0; m_fire = 0; m_txns = 0;
    end else begin
      ax_fire   = m_pend && s_ar;
      meta_fire = s_mv && exp_ready;
      m_fire    = meta_fire;
      m_done    = (m_phase == 2) && (m_cnt == 0);
      if (m_done) m_done_id = m_last_id;
      if (m_phase == 0 && meta_fire) m_phase = 1;
      else if (m_phase == 1 && ax_fire && m_ax.last) begin
        m_phase   = 2;
        m_last_id = int'(m_ax.id);
      end else if (m_phase == 2 && m_cnt == 0) m_phase = 0;
      if (ax_fire && !s_rd) m_cnt++;
      else if (s_rd && !ax_fire && m_cnt > 0) m_cnt--;
      if (ax_fire) m_txns++;
      if (meta_fire) begin
        m_ax   = expect_txn(s_g, s_s);
        m_pend = 1'b1;
      end else if (ax_fire) m_pend = 1'b0;
    end
  endtask

  task automatic send_beat(input glb_t g, input seg_t s, input bit rnd);
    s_g = g; s_s = s; s_mv = 1'b1; m_fire = 1'b0;
    for (int i = 0; i < 200 && !m_fire; i++) begin
      if (rnd) begin
        s_ar = ($urandom_range(0, 3) != 0);
        s_rd = ($urandom_range(0, 2) == 0);
      end
      step();
    end
    check_eq("accept_bound", 64'(m_fire), 64'd1);
    s_mv = 1'b0;
  endtask

  task automatic drain(input bit rnd);
    int i;
    s_mv = 1'b0;
    for (i = 0; i < 300; i++) begin
      if (m_phase == 0 && !m_pend && !m_done) break;
      s_ar = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_rd = rnd ? ($urandom_range(0, 2) == 0) : (m_cnt > 0);
      step();
    end
    s_rd = 1'b0;
    check_eq("drain_bound", 64'(i < 300), 64'd1);
  endtask

  initial begin
    glb_t g;
    seg_t s;
    int   pulses;
    rst_i = 1'b1; meta_valid_i = 1'b0; rsp_done_i = 1'b0; ax_if.ax_ready_i = 1'b0;
    meta_glb_i = '0; meta_seglv_i = '0;
    s_mv = 0; s_ar = 0; s_rd = 0; s_rst = 1; s_g = '0; s_s = '0;
    m_phase = 0; m_cnt = 0; m_pend = 0; m_ax = '0; m_done = 0; m_done_id = 0;
    m_last_id = 0; m_fire = 0; m_txns = 0;
    repeat (3) step();
    check_eq("rst_addr", ax_if.ax_addr_o, 64'd0);
    check_eq("rst_len", 64'(ax_if.ax_len_o), 64'd0);
    check_eq("rst_id", 64'(ax_if.ax_id_o), 64'd0);
    check_eq("rst_write", 64'(ax_if.ax_write_o), 64'd0);
    check_eq("rst_last", 64'(ax_if.ax_last_o), 64'd0);
    check_eq("rst_done_id", 64'(req_done_id_o), 64'd0);
    s_rst = 0;

    // Single-transaction request.
    s_ar = 1; s_rd = 0;
    g = '{reqId: 4'd1, isLoad: 1'b1, rmnGrp: 8'd0, rmnSeg: 8'd0};
    s = '{segBaseAddr: 64'h40, txnNum: 16'd0, txnCnt: 16'd0, ltN: 16'h80};
    send_beat(g, s, 1'b0);
    @(posedge clk); #1;
    check_eq("t1_addr", ax_if.ax_addr_o, 64'h20);
    check_eq("t1_len", 64'(ax_if.ax_len_o), 64'd1);
    check_eq("t1_last", 64'(ax_if.ax_last_o), 64'd1);
    check_eq("t1_write", 64'(ax_if.ax_write_o), 64'd0);
    drain(1'b0);

    // Page-crossing request.
    g = '{reqId: 4'd2, isLoad: 1'b1, rmnGrp: 8'd0, rmnSeg: 8'd0};
    s = '{segBaseAddr: 64'h1FC0, txnNum: 16'd1, txnCnt: 16'd0, ltN: 16'h20};
    send_beat(g, s, 1'b0);
    @(posedge clk); #1;
    check_eq("t2_addr0", ax_if.ax_addr_o, 64'hFE0);
    check_eq("t2_len0", 64'(ax_if.ax_len_o), 64'd1);
    check_eq("t2_last0", 64'(ax_if.ax_last_o), 64'd0);
    s.txnCnt = 16'd1;
    send_beat(g, s, 1'b0);
    @(posedge clk); #1;
    check_eq("t2_addr1", ax_if.ax_addr_o, 64'h1000);
    check_eq("t2_len1", 64'(ax_if.ax_len_o), 64'd0);
    check_eq("t2_last1", 64'(ax_if.ax_last_o), 64'd1);
    drain(1'b0);

    // Backpressure: ax held, metadata stalled, accepted as soon as ready rises.
    g = '{reqId: 4'd5, isLoad: 1'b0, rmnGrp: 8'd0, rmnSeg: 8'd0};
    s = '{segBaseAddr: 64'h2345, txnNum: 16'd2, txnCnt: 16'd0, ltN: 16'h100};
    s_ar = 0;
    send_beat(g, s, 1'b0);
    s.txnCnt = 16'd1; s_g = g; s_s = s; s_mv = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("bp_ready", 64'(meta_ready_o), 64'd0);
    end
    s_ar = 1;
    step();
    check_eq("bp_accept", 64'(meta_ready_o), 64'd1);
    s.txnCnt = 16'd2;
    send_beat(g, s, 1'b0);
    drain(1'b0);

    // Outstanding limit, then reset while draining with three responses pending.
    g = '{reqId: 4'd3, isLoad: 1'b1, rmnGrp: 8'd0, rmnSeg: 8'd0};
    s = '{segBaseAddr: 64'h0, txnNum: 16'd3, txnCnt: 16'd0, ltN: 16'h100};
    s_ar = 1; s_rd = 0;
    for (int b = 0; b < 3; b++) begin
      s.txnCnt = 16'(b);
      send_beat(g, s, 1'b0);
    end
    s.txnCnt = 16'd3; s_g = g; s_s = s; s_mv = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("lim_ready", 64'(meta_ready_o), 64'd0);
    end
    s_rd = 1; step(); s_rd = 0;
    step();
    check_eq("lim_accept", 64'(meta_ready_o), 64'd1);
    s_mv = 0;
    step();
    step();
    check_eq("drain_cnt3", 64'(m_cnt), 64'd3);
    s_rst = 1; step(); s_rst = 0;
    @(posedge clk); #1;
    check_eq("rst_ax_valid", 64'(ax_if.ax_valid_o), 64'd0);
    check_eq("rst_no_done", 64'(req_done_o), 64'd0);
    step();
    check_eq("rst_idle_ready", 64'(meta_ready_o), 64'd1);
    repeat (3) step();

    // Drain and completion pulse.
    g = '{reqId: 4'd3, isLoad: 1'b0, rmnGrp: 8'd0, rmnSeg: 8'd0};
    s = '{segBaseAddr: 64'h500, txnNum: 16'd1, txnCnt: 16'd0, ltN: 16'h40};
    send_beat(g, s, 1'b0);
    s.txnCnt = 16'd1;
    send_beat(g, s, 1'b0);
    step(); step();
    pulses = 0;
    s_rd = 1; step(); s_rd = 0; step();
    s_rd = 1; step(); s_rd = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (req_done_o) begin
        pulses++;
        check_eq("t5_id", 64'(req_done_id_o), 64'd3);
      end
    end
    check_eq("t5_pulses", 64'(pulses), 64'd1);

    // Randomized requests.
    for (int r = 0; r < 40; r++) begin
      int ngrp, nseg;
      ngrp = $urandom_range(1, 2);
      nseg = $urandom_range(1, 2);
      g.reqId  = 4'($urandom);
      g.isLoad = 1'($urandom);
      for (int gi = 0; gi < ngrp; gi++) begin
        for (int si = 0; si < nseg; si++) begin
          longint unsigned base, off;
          int tn;
          base = {24'd0, 8'($urandom), 32'($urandom)};
          off  = base % 8192;
          tn   = $urandom_range(0, 2);
          g.rmnGrp = 8'(ngrp - 1 - gi);
          g.rmnSeg = 8'(nseg - 1 - si);
          s.segBaseAddr = base;
          s.txnNum = 16'(tn);
          s.ltN = (tn == 0) ? 16'($urandom_range(int'(off) + 1, 8192)) : 16'($urandom_range(1, 8192));
          for (int t = 0; t <= tn; t++) begin
            s.txnCnt = 16'(t);
            send_beat(g, s, 1'b1);
            if ($urandom_range(0, 3) == 0) begin
              s_ar = 1'b1;
              step();
            end
          end
        end
      end
      drain(1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
